// File: rtl/result_drain_ctrl.sv
// +----------------------------------------------------------------------------+
// | result_drain_ctrl: streams len rows of the results SRAM out over valid/ready |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module result_drain_ctrl #(
  parameter int ADDRESSSIZE    = 10,
  parameter int PARTIAL_SUM_BW = 20,
  parameter int MATRIX_SIZE    = 8,
  parameter int WORDSIZE       = PARTIAL_SUM_BW * MATRIX_SIZE,
  parameter int LEN_BW         = ADDRESSSIZE + 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] base_addr,
  input  logic [LEN_BW-1:0]      len,
  input  logic                   rev_lanes,
  output logic                   busy,
  output logic                   done,
  output logic                   sram_rd_en,
  output logic [ADDRESSSIZE-1:0] sram_rd_addr,
  input  logic [WORDSIZE-1:0]    sram_rd_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WORDSIZE-1:0]    m_data,
  output logic                   m_last
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]             r_state;
  logic [ADDRESSSIZE-1:0] r_base;
  logic [LEN_BW-1:0]      r_len;
  logic                   r_rev;
  logic [LEN_BW-1:0]      r_issued;
  logic                   r_inflight;
  logic                   r_inflight_last;

  // Two-entry circular buffer; r_head points at the oldest row
  logic [WORDSIZE-1:0]    r_buf_data [2];
  logic                   r_buf_last [2];
  logic                   r_head;
  logic [1:0]             r_buf_cnt;

  logic                   w_valid;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_rd_en;
  logic                   w_wr_ptr;
  logic [1:0]             w_occ;
  logic [WORDSIZE-1:0]    w_rev_row;
  logic [WORDSIZE-1:0]    w_push_row;

  for (genvar k = 0; k < MATRIX_SIZE; k++) begin : g_lane
    assign w_rev_row[k*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] =
        sram_rd_data[(MATRIX_SIZE-1-k)*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
  end

  assign w_push_row = r_rev ? w_rev_row : sram_rd_data;
  assign w_valid    = (r_buf_cnt != 2'd0);
  assign w_pop      = w_valid && m_ready;
  assign w_push     = r_inflight;
  assign w_wr_ptr   = r_head ^ r_buf_cnt[0];
  assign w_occ      = r_buf_cnt + {1'b0, r_inflight};
  // A pop this cycle frees a slot, which keeps throughput at one row per cycle
  assign w_rd_en    = (r_state == c_run) && (r_issued < r_len) &&
                      ((w_occ < 2'd2) || w_pop);

  assign busy         = (r_state == c_run);
  assign done         = (r_state == c_done);
  assign sram_rd_en   = w_rd_en;
  assign sram_rd_addr = w_rd_en ? (r_base + r_issued[ADDRESSSIZE-1:0]) : '0;
  assign m_valid      = w_valid;
  assign m_data       = w_valid ? r_buf_data[r_head] : '0;
  assign m_last       = w_valid && r_buf_last[r_head];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state         <= c_idle;
      r_base          <= '0;
      r_len           <= '0;
      r_rev           <= 1'b0;
      r_issued        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_head          <= 1'b0;
      r_buf_cnt       <= 2'd0;
    end else begin
      case (r_state)
        c_idle: begin
          if (start) begin
            r_base   <= base_addr;
            r_len    <= len;
            r_rev    <= rev_lanes;
            r_issued <= '0;
            r_state  <= (len != '0) ? c_run : c_done;
          end
        end
        c_run: begin
          if (w_pop && r_buf_last[r_head]) r_state <= c_done;
        end
        default: r_state <= c_idle;
      endcase

      if (w_rd_en) r_issued <= r_issued + 1'b1;
      r_inflight      <= w_rd_en;
      r_inflight_last <= w_rd_en && (r_issued == r_len - 1'b1);

      if (w_push) begin
        r_buf_data[w_wr_ptr] <= w_push_row;
        r_buf_last[w_wr_ptr] <= r_inflight_last;
      end
      if (w_pop) r_head <= ~r_head;
      r_buf_cnt <= r_buf_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_result_drain_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_result_drain_ctrl: directed self-checking bench for result_drain_ctrl      |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_result_drain_ctrl;

  localparam int AW = 10;
  localparam int PW = 20;
  localparam int MS = 8;
  localparam int WW = PW * MS;
  localparam int LW = AW + 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len;
  logic          rev_lanes;
  logic          busy;
  logic          done;
  logic          sram_rd_en;
  logic [AW-1:0] sram_rd_addr;
  logic [WW-1:0] sram_rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [WW-1:0] m_data;
  logic          m_last;

  logic [WW-1:0] mem [1024];
  int            tests = 0;
  int            fails = 0;

  always #5 clk = ~clk;

  result_drain_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .base_addr    (base_addr),
    .len          (len),
    .rev_lanes    (rev_lanes),
    .busy         (busy),
    .done         (done),
    .sram_rd_en   (sram_rd_en),
    .sram_rd_addr (sram_rd_addr),
    .sram_rd_data (sram_rd_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last)
  );

  // Results SRAM with one cycle of read latency
  always_ff @(posedge clk) begin
    if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr];
  end

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] exp_row(input int addr, input logic rev);
    logic [WW-1:0] w;
    logic [WW-1:0] r;
    w = mem[addr % 1024];
    r = w;
    if (rev)
      for (int k = 0; k < MS; k++) r[k*PW +: PW] = w[(MS-1-k)*PW +: PW];
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, WW'(busy), '0);
    check({tag, "_done"}, WW'(done), '0);
    check({tag, "_rden"}, WW'(sram_rd_en), '0);
    check({tag, "_addr"}, WW'(sram_rd_addr), '0);
    check({tag, "_valid"}, WW'(m_valid), '0);
    check({tag, "_data"}, m_data, '0);
    check({tag, "_last"}, WW'(m_last), '0);
  endtask

  // Full transfer with m_ready held high; optionally pulses start while busy
  task automatic run_ready(input string tag, input int base, input int n, input logic rev,
                           input logic inject);
    start = 1'b1; base_addr = AW'(base); len = LW'(n); rev_lanes = rev;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= n + 4; k++) begin
      if (inject && k == 2) begin
        start = 1'b1; base_addr = 10'd500; len = 11'd3; rev_lanes = ~rev;
      end else begin
        start = 1'b0;
      end
      check({tag, "_busy"}, WW'(busy), WW'(k <= n + 2));
      check({tag, "_done"}, WW'(done), WW'(k == n + 3));
      check({tag, "_rden"}, WW'(sram_rd_en), WW'(k <= n));
      if (k <= n) check({tag, "_addr"}, WW'(sram_rd_addr), WW'((base + k - 1) % 1024));
      check({tag, "_valid"}, WW'(m_valid), WW'(k >= 3 && k <= n + 2));
      if (k >= 3 && k <= n + 2) begin
        check({tag, "_data"}, m_data, exp_row(base + k - 3, rev));
        check({tag, "_last"}, WW'(m_last), WW'(k == n + 2));
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    logic          prev_stall;
    logic [WW-1:0] prev_data;
    logic          prev_last;
    int            next;
    logic          seen_done;
    logic [19:0]   lane;

    for (int i = 0; i < 1024; i++) begin
      lane = 20'(i);
      mem[i] = {MS{lane}};
    end
    for (int k = 0; k < MS; k++) mem[100][k*PW +: PW] = 20'(k + 1);

    rstn = 1'b0; start = 1'b0; base_addr = '0; len = '0; rev_lanes = 1'b0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // 1: basic eight-row transfer
    run_ready("t1", 0, 8, 1'b0, 1'b0);

    // 2: toggling backpressure
    start = 1'b1; base_addr = 10'd0; len = 11'd5; rev_lanes = 1'b0;
    @(negedge clk);
    start = 1'b0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; next = 0; seen_done = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      m_ready = (c % 2 == 0);
      if (prev_stall) begin
        check("t2_stall_data", m_data, prev_data);
        check("t2_stall_last", WW'(m_last), WW'(prev_last));
      end
      if (m_valid && m_ready) begin
        check("t2_data", m_data, exp_row(next, 1'b0));
        check("t2_last", WW'(m_last), WW'(next == 4));
        next++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    m_ready = 1'b1;
    check("t2_count", WW'(next), WW'(5));
    check("t2_done_seen", WW'(seen_done), WW'(1));
    @(negedge clk);

    // 3: address wrap
    run_ready("t3", 1022, 4, 1'b0, 1'b0);

    // 4: lane reversal, then an unpermuted transfer
    run_ready("t4rev", 100, 1, 1'b1, 1'b0);
    run_ready("t4fwd", 100, 1, 1'b0, 1'b0);

    // 5: zero length, then start pulsed while busy
    start = 1'b1; base_addr = 10'd7; len = 11'd0;
    @(negedge clk);
    start = 1'b0;
    check("t5_done", WW'(done), WW'(1));
    check("t5_busy", WW'(busy), '0);
    check("t5_rden", WW'(sram_rd_en), '0);
    check("t5_valid", WW'(m_valid), '0);
    @(negedge clk);
    check("t5_done_clr", WW'(done), '0);
    check("t5_rden2", WW'(sram_rd_en), '0);
    check("t5_valid2", WW'(m_valid), '0);
    run_ready("t5busy", 10, 4, 1'b0, 1'b1);

    // 6: reset after three beats
    start = 1'b1; base_addr = 10'd0; len = 11'd8; rev_lanes = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_pre_data", m_data, exp_row(2, 1'b0));
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check_all_zero("t6_rst");
    for (int c = 0; c < 4; c++) begin
      check("t6_nodone", WW'(done), '0);
      check("t6_novalid", WW'(m_valid), '0);
      @(negedge clk);
    end
    run_ready("t6new", 0, 2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
